// File: rtl/iop_dispatch.sv
// IOP dispatcher: decodes CPU I/O instructions onto console, papertape or nonexistent lanes.
// Optional watchdog compiled in with `define IOP_DISPATCH_TIMEOUT_EN.
module iop_dispatch #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  CONSOLE_DEV    = 8'h01,
  parameter logic [7:0]  PAPERTAPE_DEV  = 8'h05
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [2:0]  iop_func,
  input  logic [10:0] iop_device,
  output logic        cpu_ack,
  output logic [1:0]  iop_cc,
  output logic [2:0]  dev_active,
  output logic [2:0]  dev_func,
  output logic [10:0] dev_device,
  input  logic [2:0]  dev_done,
  input  logic [1:0]  dev_cc,
  output logic        busy,
  output logic [15:0] op_count
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("iop_dispatch: TIMEOUT_CYCLES out of range 2..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_cpu_ack;
  logic [1:0]  r_iop_cc;
  logic [2:0]  r_dev_active;
  logic [2:0]  r_dev_func;
  logic [10:0] r_dev_device;
  logic        r_busy;
  logic [15:0] r_op_count;

  logic [2:0]  w_lane_sel;
  logic        w_func_legal;
  logic        w_sel_done;

`ifdef IOP_DISPATCH_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_cycle_cnt;
`endif

  // Lane decode from the latched request; anything off IOP 0 is nonexistent.
  always_comb begin
    w_lane_sel = 3'b100;
    if (r_dev_device[10:8] == 3'd0 && r_dev_device[7:0] == CONSOLE_DEV) begin
      w_lane_sel = 3'b001;
    end else if (r_dev_device[10:8] == 3'd0 && r_dev_device[7:0] == PAPERTAPE_DEV) begin
      w_lane_sel = 3'b010;
    end else begin
      w_lane_sel = 3'b100;
    end
  end

  assign w_func_legal = (r_dev_func[2:1] == 2'b00);
  assign w_sel_done   = |(dev_done & r_dev_active);

  // Dispatch FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cpu_ack    <= 1'b0;
      r_iop_cc     <= 2'b00;
      r_dev_active <= 3'b000;
      r_dev_func   <= 3'd0;
      r_dev_device <= 11'd0;
      r_busy       <= 1'b0;
      r_op_count   <= 16'd0;
`ifdef IOP_DISPATCH_TIMEOUT_EN
      r_cycle_cnt  <= 16'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            r_dev_func   <= iop_func;
            r_dev_device <= iop_device;
            r_busy       <= 1'b1;
            r_state      <= ST_DECODE;
          end else begin
            r_state      <= ST_IDLE;
          end
        end
        ST_DECODE: begin
          if (!w_func_legal) begin
            r_iop_cc  <= 2'b11;
            r_cpu_ack <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_dev_active <= w_lane_sel;
`ifdef IOP_DISPATCH_TIMEOUT_EN
            r_cycle_cnt  <= 16'd0;
`endif
            r_state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Completion on the selected lane takes priority over the watchdog.
          if (w_sel_done) begin
            r_iop_cc     <= dev_cc;
            r_dev_active <= 3'b000;
            r_cpu_ack    <= 1'b1;
            r_state      <= ST_DONE;
`ifdef IOP_DISPATCH_TIMEOUT_EN
          end else if (r_cycle_cnt == TIMEOUT_LAST) begin
            r_iop_cc     <= 2'b11;
            r_dev_active <= 3'b000;
            r_cpu_ack    <= 1'b1;
            r_state      <= ST_DONE;
          end else begin
            r_cycle_cnt  <= r_cycle_cnt + 16'd1;
            r_state      <= ST_RUN;
          end
`else
          end else begin
            r_state      <= ST_RUN;
          end
`endif
        end
        ST_DONE: begin
          if (!cpu_req) begin
            r_cpu_ack  <= 1'b0;
            r_busy     <= 1'b0;
            r_op_count <= r_op_count + 16'd1;
            r_state    <= ST_IDLE;
          end else begin
            r_state    <= ST_DONE;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_cpu_ack    <= 1'b0;
          r_dev_active <= 3'b000;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_ack    = r_cpu_ack;
  assign iop_cc     = r_iop_cc;
  assign dev_active = r_dev_active;
  assign dev_func   = r_dev_func;
  assign dev_device = r_dev_device;
  assign busy       = r_busy;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_iop_dispatch.sv
// Self-checking bench for iop_dispatch: vector table, hand sequences, randomized ops vs. model.
module tb_iop_dispatch;

  localparam int TO_CYC = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [2:0]  iop_func;
  logic [10:0] iop_device;
  logic        cpu_ack;
  logic [1:0]  iop_cc;
  logic [2:0]  dev_active;
  logic [2:0]  dev_func;
  logic [10:0] dev_device;
  logic [2:0]  dev_done;
  logic [1:0]  dev_cc;
  logic        busy;
  logic [15:0] op_count;

  int checks = 0;
  int failures = 0;
  int exp_ops = 0;

  iop_dispatch #(.TIMEOUT_CYCLES(TO_CYC), .CONSOLE_DEV(8'h01), .PAPERTAPE_DEV(8'h05)) dut (
    .clock(clock), .reset(reset), .cpu_req(cpu_req), .iop_func(iop_func),
    .iop_device(iop_device), .cpu_ack(cpu_ack), .iop_cc(iop_cc),
    .dev_active(dev_active), .dev_func(dev_func), .dev_device(dev_device),
    .dev_done(dev_done), .dev_cc(dev_cc), .busy(busy), .op_count(op_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  func;
    logic [10:0] dev;
    int          delay;
    logic [1:0]  cc;
    bit          spur;
    bit          drop;
    logic [2:0]  exp_act;
    logic [1:0]  exp_cc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference routing rule: only IOP 0 hosts real devices.
  function automatic logic [2:0] model_lane(input logic [2:0] f, input logic [10:0] dv);
    if (f > 3'd1) return 3'b000;
    if (dv[10:8] == 3'd0 && dv[7:0] == 8'h01) return 3'b001;
    if (dv[10:8] == 3'd0 && dv[7:0] == 8'h05) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [1:0] model_cc(input logic [2:0] f, input int d, input logic [1:0] cc);
    if (f > 3'd1) return 2'b11;
`ifdef IOP_DISPATCH_TIMEOUT_EN
    if (d > TO_CYC) return 2'b11;
`endif
    return cc;
  endfunction

  task automatic do_op(input string tag, input logic [2:0] f, input logic [10:0] dv, input int d,
                       input logic [1:0] cc, input bit spur, input bit drop,
                       input logic [2:0] exp_act, input logic [1:0] exp_cc);
    int run_len;
    run_len = d;
`ifdef IOP_DISPATCH_TIMEOUT_EN
    if (run_len > TO_CYC) run_len = TO_CYC;
`endif
    @(negedge clock);
    cpu_req = 1'b1; iop_func = f; iop_device = dv;
    @(negedge clock);
    chk({tag, "_dec_busy"}, 32'(busy), 32'd1);
    chk({tag, "_dec_active"}, 32'(dev_active), 32'd0);
    chk({tag, "_dec_func"}, 32'(dev_func), 32'(f));
    chk({tag, "_dec_device"}, 32'(dev_device), 32'(dv));
    chk({tag, "_dec_ack"}, 32'(cpu_ack), 32'd0);
    iop_func = 3'($urandom); iop_device = 11'($urandom);
    if (drop) cpu_req = 1'b0;
    if (exp_act != 3'b000) begin
      for (int k = 1; k <= run_len; k++) begin
        @(negedge clock);
        chk({tag, "_run_active"}, 32'(dev_active), 32'(exp_act));
        chk({tag, "_run_ack"}, 32'(cpu_ack), 32'd0);
        if (k == d) begin
          dev_done = exp_act; dev_cc = cc;
        end else begin
          dev_done = spur ? (~exp_act & 3'b111) : 3'b000;
          dev_cc = 2'($urandom);
        end
      end
    end
    @(negedge clock);
    dev_done = 3'b000;
    chk({tag, "_ack"}, 32'(cpu_ack), 32'd1);
    chk({tag, "_ack_active"}, 32'(dev_active), 32'd0);
    chk({tag, "_ack_cc"}, 32'(iop_cc), 32'(exp_cc));
    if (!drop) begin
      @(negedge clock);
      chk({tag, "_hold_ack"}, 32'(cpu_ack), 32'd1);
      chk({tag, "_hold_cc"}, 32'(iop_cc), 32'(exp_cc));
      cpu_req = 1'b0;
    end
    @(negedge clock);
    exp_ops++;
    chk({tag, "_idle_ack"}, 32'(cpu_ack), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_op_count"}, 32'(op_count), 32'(exp_ops[15:0]));
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{3'd0, 11'h001, 10, 2'b00, 1'b0, 1'b0, 3'b001, 2'b00};
    vecs[1] = '{3'd1, 11'h005,  4, 2'b01, 1'b1, 1'b0, 3'b010, 2'b01};
    vecs[2] = '{3'd0, 11'h107,  2, 2'b11, 1'b0, 1'b0, 3'b100, 2'b11};
    vecs[3] = '{3'd4, 11'h001,  1, 2'b00, 1'b0, 1'b0, 3'b000, 2'b11};
    vecs[4] = '{3'd0, 11'h001,  1, 2'b10, 1'b1, 1'b0, 3'b001, 2'b10};
    vecs[5] = '{3'd1, 11'h105,  3, 2'b01, 1'b0, 1'b1, 3'b100, 2'b01};
    vecs[6] = '{3'd0, 11'h002,  5, 2'b10, 1'b1, 1'b0, 3'b100, 2'b10};
    vecs[7] = '{3'd7, 11'h005,  1, 2'b00, 1'b0, 1'b1, 3'b000, 2'b11};

    reset = 1'b1; cpu_req = 1'b0; iop_func = 3'd0; iop_device = 11'd0;
    dev_done = 3'b000; dev_cc = 2'b00;
    repeat (3) @(negedge clock);
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    chk("rst_cc", 32'(iop_cc), 32'd0);
    chk("rst_active", 32'(dev_active), 32'd0);
    chk("rst_func", 32'(dev_func), 32'd0);
    chk("rst_device", 32'(dev_device), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    reset = 1'b0;

    // Reset in RUN cycle 5 of a console SIO aborts without an acknowledge.
    @(negedge clock);
    cpu_req = 1'b1; iop_func = 3'd0; iop_device = 11'h001;
    @(negedge clock);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      chk("abort_run_active", 32'(dev_active), 32'd1);
    end
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clock);
    chk("abort_active", 32'(dev_active), 32'd0);
    chk("abort_ack", 32'(cpu_ack), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_count", 32'(op_count), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("abort_no_ack", 32'(cpu_ack), 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].func, vecs[i].dev, vecs[i].delay, vecs[i].cc,
            vecs[i].spur, vecs[i].drop, vecs[i].exp_act, vecs[i].exp_cc);
    end

`ifdef IOP_DISPATCH_TIMEOUT_EN
    do_op("timeout", 3'd0, 11'h001, 40, 2'b01, 1'b0, 1'b0, 3'b001, 2'b11);
    do_op("to_tie", 3'd1, 11'h005, TO_CYC, 2'b10, 1'b0, 1'b0, 3'b010, 2'b10);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [10:0] dv;
      int          d;
      logic [1:0]  cc;
      case ($urandom_range(0, 4))
        0: dv = 11'h001;
        1: dv = 11'h005;
        2: dv = 11'h105;
        3: dv = 11'h101;
        default: dv = 11'($urandom);
      endcase
      f = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
`ifdef IOP_DISPATCH_TIMEOUT_EN
      d = $urandom_range(1, 20);
`else
      d = $urandom_range(1, 12);
`endif
      cc = 2'($urandom);
      do_op($sformatf("rnd%0d", i), f, dv, d, cc, 1'($urandom), 1'($urandom),
            model_lane(f, dv), model_cc(f, d, cc));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
